// File: rtl/policy_ram_arbiter.sv
// rtl/policy_ram_arbiter.sv - write-priority, round-robin-read sequencer for a shared 16x32 policy RAM
// Optional ARB_TIMEOUT_EN: a read stuck in WAIT for TIMEOUT cycles completes with rd_err and zero data.
module policy_ram_arbiter #(
  parameter int TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ack,
  input  logic        rd_req0,
  input  logic [3:0]  rd_addr0,
  input  logic        rd_req1,
  input  logic [3:0]  rd_addr1,
  output logic        rd_ack0,
  output logic        rd_ack1,
  output logic [31:0] rd_data0,
  output logic [31:0] rd_data1,
  output logic        rd_err,
  output logic        ram_wen,
  output logic [3:0]  ram_waddr,
  output logic [31:0] ram_wdata,
  output logic        ram_go_read,
  output logic [3:0]  ram_raddr,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, ACK} state_t;

  state_t      state;
  logic        rr_last;
  logic        wr_last;
  logic        grant_id;
  logic [3:0]  addr_q;
  logic [31:0] wdata_q;
  logic        rd_pending;
  logic        pick1;
  logic        take_write;

  // A write wins unless the previous grant was also a write and a read is waiting.
  always_comb begin
    rd_pending = rd_req0 | rd_req1;
    pick1      = rr_last ? ~rd_req0 : rd_req1;
    take_write = wr_req & (~rd_pending | ~wr_last);
  end

  assign ram_waddr = addr_q;
  assign ram_raddr = addr_q;
  assign ram_wdata = wdata_q;

`ifdef ARB_TIMEOUT_EN
  logic [3:0] wait_cnt;
  logic       timed_out;
  assign timed_out = (wait_cnt == 4'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^4'(TIMEOUT);
  assign rd_err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_last     <= 1'b1;
      wr_last     <= 1'b0;
      grant_id    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_ack      <= 1'b0;
      ram_wen     <= 1'b0;
      ram_go_read <= 1'b0;
      rd_ack0     <= 1'b0;
      rd_ack1     <= 1'b0;
      rd_data0    <= '0;
      rd_data1    <= '0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt    <= '0;
      rd_err      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (take_write) begin
            state   <= WRITE;
            addr_q  <= wr_addr;
            wdata_q <= wr_data;
            ram_wen <= 1'b1;
            wr_ack  <= 1'b1;
          end else if (rd_pending) begin
            state       <= READ;
            grant_id    <= pick1;
            addr_q      <= pick1 ? rd_addr1 : rd_addr0;
            ram_go_read <= 1'b1;
          end
        end
        WRITE: begin
          ram_wen <= 1'b0;
          wr_ack  <= 1'b0;
          wr_last <= 1'b1;
          state   <= IDLE;
        end
        READ: begin
          ram_go_read <= 1'b0;
          wr_last     <= 1'b0;
          rr_last     <= grant_id;
          state       <= WAIT;
`ifdef ARB_TIMEOUT_EN
          wait_cnt    <= '0;
`endif
        end
        WAIT: begin
          // A late ram_ready still beats a coincident timeout.
          if (ram_ready) begin
            state    <= ACK;
            rd_ack0  <= ~grant_id;
            rd_ack1  <= grant_id;
            rd_data0 <= grant_id ? '0 : ram_rdata;
            rd_data1 <= grant_id ? ram_rdata : '0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (timed_out) begin
            state   <= ACK;
            rd_ack0 <= ~grant_id;
            rd_ack1 <= grant_id;
            rd_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
`endif
        end
        ACK: begin
          rd_ack0  <= 1'b0;
          rd_ack1  <= 1'b0;
          rd_data0 <= '0;
          rd_data1 <= '0;
`ifdef ARB_TIMEOUT_EN
          rd_err   <= 1'b0;
`endif
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_policy_ram_arbiter.sv
// tb/tb_policy_ram_arbiter.sv - self-checking bench for policy_ram_arbiter against a transaction-level model
module tb_policy_ram_arbiter;
  logic        clk, rst;
  logic        wr_req, rd_req0, rd_req1;
  logic [3:0]  wr_addr, rd_addr0, rd_addr1;
  logic [31:0] wr_data;
  logic        wr_ack, rd_ack0, rd_ack1, rd_err, ram_wen, ram_go_read;
  logic [31:0] rd_data0, rd_data1, ram_wdata, ram_rdata;
  logic [3:0]  ram_waddr, ram_raddr;
  logic        ram_ready;

  policy_ram_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req0(rd_req0), .rd_addr0(rd_addr0), .rd_req1(rd_req1), .rd_addr1(rd_addr1),
    .rd_ack0(rd_ack0), .rd_ack1(rd_ack1), .rd_data0(rd_data0), .rd_data1(rd_data1),
    .rd_err(rd_err), .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_go_read(ram_go_read), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // RAM stub: registered response, optionally delayed by stub_delay extra cycles.
  logic [31:0] mem [16];
  int          stub_delay;
  int          pend_cnt;
  logic [3:0]  pend_addr;
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    pend_cnt  = 0;
    pend_addr = 4'h0;
    ram_ready = 1'b0;
    ram_rdata = 32'h0;
    forever begin
      @(posedge clk);
      ram_ready <= 1'b0;
      ram_rdata <= 32'hDEAD_BEEF;
      if (ram_wen) mem[ram_waddr] <= ram_wdata;
      if (ram_go_read) begin
        if (stub_delay == 0) begin
          ram_ready <= 1'b1;
          ram_rdata <= mem[ram_raddr];
        end else begin
          pend_cnt  <= stub_delay;
          pend_addr <= ram_raddr;
        end
      end else if (pend_cnt != 0) begin
        pend_cnt <= pend_cnt - 1;
        if (pend_cnt == 1) begin
          ram_ready <= 1'b1;
          ram_rdata <= mem[pend_addr];
        end
      end
    end
  end

  // Transaction-level model: a grant occupies the bus for 2 (write) or 4 (read) cycles.
  bit          model_en;
  logic [31:0] ref_mem [16];
  logic        e_wack, e_wen, e_go, e_ack0, e_ack1;
  logic [3:0]  e_waddr, e_raddr;
  logic [31:0] e_wdata, e_data0, e_data1;
  bit          m_busy, m_is_wr, m_last_wr, m_last_rd, m_id, m_pref;
  int          m_k;
  logic [3:0]  m_addr;
  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    m_busy = 0; m_is_wr = 0; m_last_wr = 0; m_last_rd = 1; m_k = 0; m_addr = 4'h0;
    e_waddr = 4'h0; e_raddr = 4'h0; e_wdata = 32'h0;
    forever begin
      @(posedge clk);
      e_wack = 0; e_wen = 0; e_go = 0; e_ack0 = 0; e_ack1 = 0; e_data0 = 0; e_data1 = 0;
      if (rst) begin
        m_busy = 0; m_last_wr = 0; m_last_rd = 1;
      end else if (m_busy) begin
        m_k++;
        if (!m_is_wr && m_k == 2) begin
          if (m_id) begin e_ack1 = 1; e_data1 = ref_mem[m_addr]; end
          else begin e_ack0 = 1; e_data0 = ref_mem[m_addr]; end
        end
        if (m_k == (m_is_wr ? 1 : 3)) m_busy = 0;
      end else if (wr_req && (!(rd_req0 || rd_req1) || !m_last_wr)) begin
        m_busy = 1; m_k = 0; m_is_wr = 1; m_last_wr = 1;
        ref_mem[wr_addr] = wr_data;
        e_wen = 1; e_wack = 1; e_waddr = wr_addr; e_wdata = wr_data;
      end else if (rd_req0 || rd_req1) begin
        m_pref = !m_last_rd;
        if ((m_pref && rd_req1) || (!m_pref && rd_req0)) m_id = m_pref;
        else m_id = !m_pref;
        m_busy = 1; m_k = 0; m_is_wr = 0; m_last_wr = 0; m_last_rd = m_id;
        m_addr = m_id ? rd_addr1 : rd_addr0;
        e_go = 1; e_raddr = m_addr;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (model_en) begin
      check("wr_ack", wr_ack, e_wack);
      check("ram_wen", ram_wen, e_wen);
      check("ram_go_read", ram_go_read, e_go);
      check("rd_ack0", rd_ack0, e_ack0);
      check("rd_ack1", rd_ack1, e_ack1);
      check("rd_data0", rd_data0, e_data0);
      check("rd_data1", rd_data1, e_data1);
      check("rd_err", rd_err, 0);
      check("wen_go_exclusive", ram_wen & ram_go_read, 0);
      if (e_wen) begin
        check("ram_waddr", ram_waddr, e_waddr);
        check("ram_wdata", ram_wdata, e_wdata);
      end
      if (e_go) check("ram_raddr", ram_raddr, e_raddr);
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_wr_ack"}, wr_ack, 0);
    check({tag, "_ram_wen"}, ram_wen, 0);
    check({tag, "_ram_go_read"}, ram_go_read, 0);
    check({tag, "_rd_ack0"}, rd_ack0, 0);
    check({tag, "_rd_ack1"}, rd_ack1, 0);
    check({tag, "_rd_data0"}, rd_data0, 0);
    check({tag, "_rd_data1"}, rd_data1, 0);
    check({tag, "_rd_err"}, rd_err, 0);
    check({tag, "_ram_waddr"}, ram_waddr, 0);
    check({tag, "_ram_wdata"}, ram_wdata, 0);
    check({tag, "_ram_raddr"}, ram_raddr, 0);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    wr_req = 1; wr_addr = a; wr_data = d;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (wr_ack) break;
    end
    check("preload_ack", wr_ack, 1);
    wr_req = 0;
    tick;
  endtask

  int          ev [4];
  int          n_ev, ack_at, acks, diffs;
  logic [31:0] snap [16];

  initial begin
    rst = 1; wr_req = 0; rd_req0 = 0; rd_req1 = 0;
    wr_addr = 0; rd_addr0 = 0; rd_addr1 = 0; wr_data = 0; stub_delay = 0;
    tick; tick;
    rst = 0;
    check_quiet("reset");
    model_en = 1;

    // Write then read back with exact cycle positions.
    wr_req = 1; wr_addr = 4'd3; wr_data = 32'hA5A5_0003;
    tick;
    check("t1_wr_ack", wr_ack, 1);
    check("t1_waddr", ram_waddr, 3);
    check("t1_wdata", ram_wdata, 32'hA5A5_0003);
    wr_req = 0;
    tick;
    check("t1_wr_ack_low", wr_ack, 0);
    rd_req0 = 1; rd_addr0 = 4'd3;
    tick;
    check("t1_go_read", ram_go_read, 1);
    check("t1_raddr", ram_raddr, 3);
    tick;
    check("t1_no_early_ack", rd_ack0, 0);
    tick;
    check("t1_rd_ack0", rd_ack0, 1);
    check("t1_rd_data0", rd_data0, 32'hA5A5_0003);
    rd_req0 = 0;
    tick;
    check("t1_rd_ack0_low", rd_ack0, 0);

    // Both readers held: round-robin starting at reader 0.
    rst = 1; tick; rst = 0;
    do_write(4'd1, 32'h11);
    do_write(4'd2, 32'h22);
    rd_req0 = 1; rd_addr0 = 4'd1; rd_req1 = 1; rd_addr1 = 4'd2; n_ev = 0;
    for (int c = 0; c < 40 && n_ev < 4; c++) begin
      tick;
      check("rr_no_dual_ack", rd_ack0 & rd_ack1, 0);
      if (rd_ack0) begin check("rr_data0", rd_data0, 32'h11); ev[n_ev] = 0; n_ev++; end
      else if (rd_ack1) begin check("rr_data1", rd_data1, 32'h22); ev[n_ev] = 1; n_ev++; end
    end
    rd_req0 = 0; rd_req1 = 0;
    check("rr_grants_seen", n_ev, 4);
    for (int i = 0; i < n_ev; i++) check("rr_order", ev[i], i % 2);

    // Write and reader 1 held together: strict alternation W, R1, W, R1.
    wr_req = 1; wr_addr = 4'd5; wr_data = 32'h5555_AAAA;
    rd_req1 = 1; rd_addr1 = 4'd5; n_ev = 0;
    for (int c = 0; c < 40 && n_ev < 4; c++) begin
      tick;
      check("alt_wen_go", ram_wen & ram_go_read, 0);
      if (wr_ack) begin ev[n_ev] = 0; n_ev++; end
      else if (rd_ack1) begin check("alt_data1", rd_data1, 32'h5555_AAAA); ev[n_ev] = 1; n_ev++; end
    end
    wr_req = 0; rd_req1 = 0;
    check("alt_grants_seen", n_ev, 4);
    for (int i = 0; i < n_ev; i++) check("alt_order", ev[i], i % 2);
    tick; tick; tick;

    // Reset during WAIT abandons the read.
    for (int i = 0; i < 16; i++) snap[i] = mem[i];
    rd_req0 = 1; rd_addr0 = 4'd3;
    tick;
    check("rw_go_read", ram_go_read, 1);
    tick;
    rst = 1;
    tick;
    rst = 0; rd_req0 = 0;
    check_quiet("rw_after_rst");
    tick;
    check("rw_no_ack_a", rd_ack0, 0);
    tick;
    check("rw_no_ack_b", rd_ack0, 0);
    diffs = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== snap[i]) diffs++;
    check("rw_mem_unchanged", diffs, 0);
    wr_req = 1; wr_addr = 4'd9; wr_data = 32'h0000_0999;
    tick;
    check("rw_idle_write_ack", wr_ack, 1);
    wr_req = 0;
    tick;

    // RAM withholds ram_ready for 8 extra cycles.
    model_en = 0; stub_delay = 8;
    rd_req0 = 1; rd_addr0 = 4'd3; ack_at = 0;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (rd_ack0) begin ack_at = c; break; end
    end
    rd_req0 = 0;
`ifdef ARB_TIMEOUT_EN
    check("to_ack_cycle", ack_at, 6);
    check("to_rd_data0", rd_data0, 0);
    check("to_rd_err", rd_err, 1);
`else
    check("slow_ack_cycle", ack_at, 11);
    check("slow_rd_data0", rd_data0, 32'hA5A5_0003);
    check("slow_rd_err", rd_err, 0);
`endif
    repeat (15) tick;
    stub_delay = 0;
    rst = 1; tick; rst = 0;
    model_en = 1;

    // Randomized traffic against the model.
    acks = 0;
    for (int c = 0; c < 3000; c++) begin
      tick;
      if (wr_ack) acks++;
      if (rd_ack0) acks++;
      if (rd_ack1) acks++;
      if (wr_ack || !wr_req) begin
        wr_req = ($urandom_range(0, 2) == 0);
        wr_addr = 4'($urandom); wr_data = $urandom;
      end
      if (rd_ack0 || !rd_req0) begin
        rd_req0 = ($urandom_range(0, 2) == 0);
        rd_addr0 = 4'($urandom);
      end
      if (rd_ack1 || !rd_req1) begin
        rd_req1 = ($urandom_range(0, 2) == 0);
        rd_addr1 = 4'($urandom);
      end
    end
    wr_req = 0; rd_req0 = 0; rd_req1 = 0;
    repeat (6) tick;
    check("random_progress", acks > 100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
